// File: rtl/inst_mem_ctl.sv
// -----------------------------------------------------------------------------
// inst_mem_ctl
//   Instruction memory for the fetch stage of the RISC-V core. Holds a
//   DEPTH x DATA_W word array with one synchronous fetch port and one
//   synchronous byte-enabled loader write port.
//
//   After reset a fill sequencer writes FILL (a NOP) to every word, one word
//   per edge. While it runs, busy is high and both ports are ignored.
//   When the fill finishes the block enters READY and stays there until the
//   next reset.
//
//   A fetch that samples the address being written on the same edge returns
//   the post-write word (write-first). stall freezes rd_data/rd_valid; the
//   request presented during a stall is dropped, not queued.
//
// Ports
//   clk      : clock, rising edge active
//   rst      : asynchronous active-high reset
//   wr_en    : loader write request
//   wr_be    : byte enables, bit i covers wr_data[8i+7:8i]
//   wr_addr  : loader word address
//   wr_data  : loader write data
//   rd_en    : fetch request
//   rd_addr  : fetch word address
//   stall    : hold fetch outputs, ignore rd_en
//   rd_data  : registered fetch data
//   rd_valid : rd_data holds the result of an accepted fetch
//   busy     : fill in progress, requests ignored
// -----------------------------------------------------------------------------
module inst_mem_ctl #(
  parameter int          DATA_W = 32,
  parameter int          ADDR_W = 10,
  parameter logic [31:0] FILL   = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  input  logic                stall,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic                busy
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  // FILL is truncated or zero-extended to the word width.
  localparam logic [DATA_W-1:0] FILL_WORD = DATA_W'(FILL);
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Replace the enabled byte lanes of old_word with the lanes of new_word.
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [NB-1:0]     be
  );
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return res;
  endfunction

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  state_t            state_r;
  state_t            state_nxt_s;
  logic [ADDR_W-1:0] fill_cnt_r;
  logic              busy_s;

  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_data_s;
  logic [NB-1:0]     mem_be_s;

  logic              wr_hit_s;
  logic [DATA_W-1:0] rd_word_s;
  logic [DATA_W-1:0] rd_fwd_s;

  logic [DATA_W-1:0] rd_data_r;
  logic              rd_valid_r;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_FILL;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: leave FILL on the edge that writes the last address.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_FILL: begin
        if (fill_cnt_r == LAST_ADDR) begin
          state_nxt_s = ST_READY;
        end else begin
          state_nxt_s = ST_FILL;
        end
      end
      ST_READY: state_nxt_s = ST_READY;
      default:  state_nxt_s = ST_FILL;
    endcase
  end

  // FSM outputs: busy is a pure decode of the state register.
  always_comb begin
    busy_s = 1'b1;
    case (state_r)
      ST_FILL:  busy_s = 1'b1;
      ST_READY: busy_s = 1'b0;
      default:  busy_s = 1'b1;
    endcase
  end

  // Fill address counter. Leaving FILL at LAST_ADDR means it never wraps into a refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_cnt_r <= {ADDR_W{1'b0}};
    end else if (state_r == ST_FILL) begin
      fill_cnt_r <= fill_cnt_r + ADDR_ONE;
    end else begin
      fill_cnt_r <= fill_cnt_r;
    end
  end

  // Write-port mux: the fill sequencer owns the array until READY.
  always_comb begin
    mem_addr_s = wr_addr;
    mem_data_s = wr_data;
    mem_be_s   = {NB{1'b0}};
    if (state_r == ST_FILL) begin
      mem_addr_s = fill_cnt_r;
      mem_data_s = FILL_WORD;
      mem_be_s   = {NB{1'b1}};
    end else if (wr_en) begin
      mem_addr_s = wr_addr;
      mem_data_s = wr_data;
      mem_be_s   = wr_be;
    end else begin
      mem_addr_s = wr_addr;
      mem_data_s = wr_data;
      mem_be_s   = {NB{1'b0}};
    end
  end

  // Array update. Each byte lane has its own write enable.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (mem_be_s[i]) begin
        mem[mem_addr_s][8*i +: 8] <= mem_data_s[8*i +: 8];
      end
    end
  end

  // Write-first forwarding: a same-edge write to the fetched word patches its enabled lanes.
  always_comb begin
    rd_word_s = mem[rd_addr];
    wr_hit_s  = (state_r == ST_READY) && wr_en && (wr_addr == rd_addr);
    if (wr_hit_s) begin
      rd_fwd_s = merge_bytes(rd_word_s, wr_data, wr_be);
    end else begin
      rd_fwd_s = rd_word_s;
    end
  end

  // Fetch output register with stall hold and idle invalidation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_r  <= {DATA_W{1'b0}};
      rd_valid_r <= 1'b0;
    end else if (state_r == ST_FILL) begin
      rd_data_r  <= rd_data_r;
      rd_valid_r <= 1'b0;
    end else if (stall) begin
      rd_data_r  <= rd_data_r;
      rd_valid_r <= rd_valid_r;
    end else if (rd_en) begin
      rd_data_r  <= rd_fwd_s;
      rd_valid_r <= 1'b1;
    end else begin
      rd_data_r  <= rd_data_r;
      rd_valid_r <= 1'b0;
    end
  end

  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign busy     = busy_s;

endmodule

// File: tb/tb_inst_mem_ctl.sv
module tb_inst_mem_ctl;

  localparam int DEPTH = 1024;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_be;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic        stall;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        busy;

  inst_mem_ctl #(.DATA_W(32), .ADDR_W(10), .FILL(32'h0000_0013)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .stall(stall),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        busy;
    logic        valid;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  // reference model: architectural view of the memory and fetch port
  logic [31:0] m_mem [0:DEPTH-1];
  int          m_fill;
  logic        m_valid;
  logic [31:0] m_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // one clock cycle of stimulus; the model predicts the state after the next rising edge
  task automatic drive(input logic r, input logic we, input logic [3:0] be,
                       input logic [9:0] wa, input logic [31:0] wd,
                       input logic re, input logic [9:0] ra, input logic st);
    exp_t e;
    @(negedge clk);
    rst = r; wr_en = we; wr_be = be; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr = ra; stall = st;
    if (r) begin
      #1;
      chk("async_rst_valid", {31'd0, rd_valid}, 32'd0);
      chk("async_rst_data", rd_data, 32'd0);
      chk("async_rst_busy", {31'd0, busy}, 32'd1);
      for (int i = 0; i < DEPTH; i++) m_mem[i] = NOP;  // contents are invisible until fill completes
      m_fill = 0; m_valid = 1'b0; m_data = 32'd0;
    end else if (m_fill < DEPTH) begin
      m_fill++;
      m_valid = 1'b0;
    end else begin
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) m_mem[wa][8*b +: 8] = wd[8*b +: 8];
      end
      if (!st) begin
        if (re) begin
          m_valid = 1'b1;
          m_data  = m_mem[ra];
        end else begin
          m_valid = 1'b0;
        end
      end
    end
    e.busy = (m_fill < DEPTH); e.valid = m_valid; e.data = m_data;
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'h0, 10'd0, 32'd0, 1'b0, 10'd0, 1'b0);
  endtask

  // monitor: compares DUT outputs against the expectation queued for the last edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("busy", {31'd0, busy}, {31'd0, e.busy});
        chk("rd_valid", {31'd0, rd_valid}, {31'd0, e.valid});
        chk("rd_data", rd_data, e.data);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_be = 4'h0; wr_addr = 10'd0; wr_data = 32'd0;
    rd_en = 1'b0; rd_addr = 10'd0; stall = 1'b0;

    // reset, then fill with fetch held at addr 5 and junk writes that must be ignored
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 4'h0, 10'd0, 32'd0, 1'b1, 10'd5, 1'b0);
    for (int i = 0; i < DEPTH; i++)
      drive(1'b0, 1'b1, 4'hF, 10'd5, $urandom, 1'b1, 10'd5, $urandom_range(0, 1) == 1);
    drive(1'b0, 1'b0, 4'h0, 10'd0, 32'd0, 1'b1, 10'd5, 1'b0);

    // byte-enable merge on addr 3
    drive(1'b0, 1'b1, 4'hF, 10'd3, 32'hAABB_CCDD, 1'b0, 10'd0, 1'b0);
    drive(1'b0, 1'b1, 4'h5, 10'd3, 32'h1122_3344, 1'b0, 10'd0, 1'b0);
    drive(1'b0, 1'b0, 4'h0, 10'd0, 32'd0, 1'b1, 10'd3, 1'b0);
    // legal no-op write (be = 0)
    drive(1'b0, 1'b1, 4'h0, 10'd3, 32'hFFFF_FFFF, 1'b0, 10'd0, 1'b0);
    drive(1'b0, 1'b0, 4'h0, 10'd0, 32'd0, 1'b1, 10'd3, 1'b0);

    // same-edge write/read forwarding on addr 7
    drive(1'b0, 1'b1, 4'hC, 10'd7, 32'hDEAD_BEEF, 1'b1, 10'd7, 1'b0);

    // stall hold
    drive(1'b0, 1'b1, 4'hF, 10'd1, 32'h0101_0101, 1'b0, 10'd0, 1'b0);
    drive(1'b0, 1'b1, 4'hF, 10'd2, 32'h0202_0202, 1'b1, 10'd1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 4'h0, 10'd0, 32'd0, 1'b1, 10'd2, 1'b1);
    drive(1'b0, 1'b0, 4'h0, 10'd0, 32'd0, 1'b1, 10'd2, 1'b0);

    // back-to-back stream of 16 words
    for (int n = 0; n < 16; n++) drive(1'b0, 1'b1, 4'hF, 10'(n), 32'(n * 4), 1'b0, 10'd0, 1'b0);
    for (int n = 0; n < 16; n++) drive(1'b0, 1'b0, 4'h0, 10'd0, 32'd0, 1'b1, 10'(n), 1'b0);
    idle(2);

    // randomized traffic on a small window so collisions are frequent
    for (int i = 0; i < 400; i++)
      drive(1'b0, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), 10'($urandom_range(0, 15)),
            $urandom, $urandom_range(0, 3) != 0, 10'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);

    // reset in the middle of a stream, then refill and read back
    for (int n = 0; n < 6; n++) drive(1'b0, 1'b0, 4'h0, 10'd0, 32'd0, 1'b1, 10'(n), 1'b0);
    drive(1'b1, 1'b0, 4'h0, 10'd0, 32'd0, 1'b1, 10'd6, 1'b0);
    drive(1'b1, 1'b0, 4'h0, 10'd0, 32'd0, 1'b1, 10'd7, 1'b0);
    idle(DEPTH);
    for (int n = 0; n < 16; n++) drive(1'b0, 1'b0, 4'h0, 10'd0, 32'd0, 1'b1, 10'(n), 1'b0);
    idle(2);

    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_mem_ctl.md
# inst_mem_ctl

Parametrised instruction memory for the RISC-V core fetch stage: one synchronous read (fetch) port and one synchronous write (loader) port over a DEPTH x DATA_W array. Adds byte-enabled writes, write-first read-during-write forwarding, a fetch stall/hold with a read-valid flag, and a post-reset fill sequencer that initialises every word to a NOP before fetch is allowed. Sits between the PC/fetch logic and the program loader.

## Interface

Parameters:
- DATA_W, 32: word width in bits; must be a multiple of 8.
- ADDR_W, 10: address width; DEPTH = 2**ADDR_W words (default 1K).
- FILL, 32'h0000_0013: value written to every word during fill (RISC-V `addi x0,x0,0`), truncated or zero-extended to DATA_W.

Ports:
- clk, input, 1: single clock; all state updates on rising edge.
- rst, input, 1: asynchronous, active-high reset.
- wr_en, input, 1: write request.
- wr_be, input, DATA_W/8: byte enables; bit i covers data bits [8i+7:8i].
- wr_addr, input, ADDR_W: write word address.
- wr_data, input, DATA_W: write data.
- rd_en, input, 1: fetch request.
- rd_addr, input, ADDR_W: fetch word address.
- stall, input, 1: hold fetch output.
- rd_data, output, DATA_W: registered fetch data.
- rd_valid, output, 1: rd_data holds the result of an accepted fetch.
- busy, output, 1: fill in progress; ports ignored.

## Operation

- States: FILL, READY. Reset forces FILL, fill counter = 0.
- FILL: each edge writes FILL to mem[counter], counter += 1. On the edge writing address DEPTH-1 → READY. wr_en, rd_en, stall ignored; rd_valid held 0; busy = 1.
- READY: busy = 0; stays in READY until rst.
- Write (READY, wr_en=1): for each i with wr_be[i]=1, mem[wr_addr] byte i ← wr_data byte i; other bytes unchanged. wr_be = 0 is a legal no-op.
- Fetch (READY, rd_en=1, stall=0): rd_data ← mem[rd_addr], rd_valid ← 1.
- Idle (READY, rd_en=0, stall=0): rd_valid ← 0; rd_data holds its last value.
- Stall (READY, stall=1): rd_data and rd_valid hold; rd_en ignored; writes still proceed.
- Read-during-write, same address, same edge: write-first; rd_data = old word with enabled bytes replaced by wr_data bytes. Different addresses: independent.
- Reset mid-operation (in either state): immediately rd_valid=0, rd_data=0, busy=1; fill restarts at address 0. Array contents are not cleared asynchronously; the fill overwrites them.

## Timing

- Reset values: rd_data = 0, rd_valid = 0, busy = 1, state FILL, counter = 0.
- Fill length: exactly DEPTH rising edges after rst deasserts. busy falls after edge DEPTH. The first request accepted is the one sampled at edge DEPTH+1.
- Read latency: 1 cycle. Address sampled at edge t; rd_data/rd_valid valid after edge t. Back-to-back fetches sustain one word per cycle.
- Write latency: visible to a fetch of the same address sampled at the same edge (forwarding) and to every later edge.
- stall acts at the edge it is sampled at. A request presented with stall=1 is dropped, not queued; the fetch stage re-presents it.
- Counter wrap: counter is ADDR_W bits. The transition to READY on address DEPTH-1 prevents any wrap refill.

## Test plan

- Fill: deassert rst, hold rd_en=1, rd_addr=5 throughout → busy=1 and rd_valid=0 for 1024 edges. busy=0 after edge 1024; next edge rd_data=32'h0000_0013, rd_valid=1.
- Byte-enable write: write 32'hAABB_CCDD with be=4'b1111 to addr 3, then 32'h1122_3344 with be=4'b0101 to addr 3; fetch addr 3 → 32'hAA22_CC44.
- Forwarding: addr 7 holds 32'h0000_0013. Same edge: wr_en, be=4'b1100, wr_data=32'hDEAD_BEEF at addr 7, and rd_en at addr 7 → rd_data=32'hDEAD_0013 next cycle.
- Stall/hold: fetch addr 1 (rd_data=X1, rd_valid=1); assert stall for 3 cycles while rd_addr=2 → rd_data stays X1, rd_valid stays 1. Release stall with rd_en=1, addr 2 → mem[2] after one edge.
- Back-to-back stream: fetch addrs 0..15 consecutively after writing word n=n*4 → rd_data sequence 0,4,…,60 with one-cycle latency and no bubbles; rd_en=0 → rd_valid=0 next cycle.
- Reset mid-stream: assert rst during streaming → rd_valid=0, rd_data=0, busy=1 immediately. After release, 1024 fill edges; all previously written words read back 32'h0000_0013.
